demux32b_stream: RTL and testbench

//  Registered 1-to-2 demultiplexer for 32-bit datapath words; the inverse of the 2:1 word mux.

---
 rtl/demux_pkg.sv | 16 +
 rtl/demux_out_fifo.sv | 74 +++++++
 rtl/demux32b_stream.sv | 59 +++++
 tb/tb_demux32b_stream.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared defaults and helpers for the 1-to-2 word demultiplexer.
package demux_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 2;
    localparam int unsigned DEF_CNT_W = 8;

    // Address bits for a DEPTH-entry FIFO; never below 1 so pointer slices stay legal.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 1;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/demux_out_fifo.sv
// Per-destination sync FIFO with valid/ready output and a delivered-word counter.
module demux_out_fifo
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ready,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             empty;
    logic             pop;
    logic             do_push;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        valid    = !empty;
        pop      = valid && ready;
        do_push  = push && !full;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            last_d   = mem_q[rd_ptr_q[AW-1:0]];
            rd_ptr_d = rd_ptr_q + PW'(1);
            cnt_d    = cnt_q + CNT_W'(1);
        end
        // Once drained, keep showing the most recently delivered word.
        rdata = empty ? last_q : mem_q[rd_ptr_q[AW-1:0]];
        count = cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/demux32b_stream.sv
// Registered 1-to-2 stream demultiplexer: each word is steered by En into its own output FIFO.
module demux32b_stream
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             En,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic [WIDTH-1:0] Data0,
    output logic             Out0_Valid,
    input  logic             Out0_Ready,
    output logic [WIDTH-1:0] Data1,
    output logic             Out1_Valid,
    input  logic             Out1_Ready,
    output logic [CNT_W-1:0] Count0,
    output logic [CNT_W-1:0] Count1
);

    logic full0, full1;
    logic push0, push1;

    // Acceptance depends only on the selected FIFO's fullness, never on consumer ready.
    always_comb begin
        In_Ready = En ? !full1 : !full0;
        push0    = In_Valid && In_Ready && !En;
        push1    = In_Valid && In_Ready && En;
    end

    demux_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo0 (
        .clk   (clk),
        .rst   (rst),
        .push  (push0),
        .wdata (DataIn),
        .ready (Out0_Ready),
        .full  (full0),
        .valid (Out0_Valid),
        .rdata (Data0),
        .count (Count0)
    );

    demux_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo1 (
        .clk   (clk),
        .rst   (rst),
        .push  (push1),
        .wdata (DataIn),
        .ready (Out1_Ready),
        .full  (full1),
        .valid (Out1_Valid),
        .rdata (Data1),
        .count (Count1)
    );

endmodule

// File: tb/tb_demux32b_stream.sv
// Scoreboard bench for demux32b_stream: occupancy-based reference model plus an independent output monitor.
module tb_demux32b_stream;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        En = 1'b0;
    logic [31:0] DataIn = '0;
    logic        In_Valid = 1'b0;
    logic        In_Ready;
    logic [31:0] Data0, Data1;
    logic        Out0_Valid, Out1_Valid;
    logic        Out0_Ready = 1'b0;
    logic        Out1_Ready = 1'b0;
    logic [7:0]  Count0, Count1;

    int unsigned npass  = 0;
    int unsigned ntotal = 0;

    logic [31:0] sb0[$];
    logic [31:0] sb1[$];
    int          occ0 = 0;
    int          occ1 = 0;
    int unsigned cnt0 = 0;
    int unsigned cnt1 = 0;

    always #5 clk = ~clk;

    demux32b_stream #(.WIDTH(32), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .En         (En),
        .DataIn     (DataIn),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .Data0      (Data0),
        .Out0_Valid (Out0_Valid),
        .Out0_Ready (Out0_Ready),
        .Data1      (Data1),
        .Out1_Valid (Out1_Valid),
        .Out1_Ready (Out1_Ready),
        .Count0     (Count0),
        .Count1     (Count1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every handshake the DUT presents must match the oldest expected word.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b0) begin
                if (Out0_Valid === 1'b1 && Out0_Ready) begin
                    if (sb0.size() == 0) begin
                        ntotal++;
                        $display("FAIL data0: unexpected word %h with empty scoreboard", Data0);
                    end else chk("data0", Data0, sb0.pop_front());
                end
                if (Out1_Valid === 1'b1 && Out1_Ready) begin
                    if (sb1.size() == 0) begin
                        ntotal++;
                        $display("FAIL data1: unexpected word %h with empty scoreboard", Data1);
                    end else chk("data1", Data1, sb1.pop_front());
                end
            end
        end
    end

    task automatic cycle(input bit v, input bit e, input logic [31:0] d,
                         input bit r0, input bit r1, output bit acc);
        bit room, p0, p1;
        @(negedge clk);
        chk("count0", Count0, cnt0);
        chk("count1", Count1, cnt1);
        In_Valid   = v;
        En         = e;
        DataIn     = d;
        Out0_Ready = r0;
        Out1_Ready = r1;
        room = ((e ? occ1 : occ0) < DEPTH);
        acc  = v && room;
        p0   = r0 && (occ0 > 0);
        p1   = r1 && (occ1 > 0);
        #1;
        chk("in_ready", In_Ready, room);
        chk("out0_valid", Out0_Valid, occ0 > 0);
        chk("out1_valid", Out1_Valid, occ1 > 0);
        @(posedge clk);
        if (acc) begin
            if (e) begin sb1.push_back(d); occ1++; end
            else   begin sb0.push_back(d); occ0++; end
        end
        if (p0) begin occ0--; cnt0 = (cnt0 + 1) % 256; end
        if (p1) begin occ1--; cnt1 = (cnt1 + 1) % 256; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        In_Valid   = 1'b0;
        Out0_Ready = 1'b0;
        Out1_Ready = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("rst_out0_valid", Out0_Valid, 0);
        chk("rst_out1_valid", Out1_Valid, 0);
        chk("rst_count0", Count0, 0);
        chk("rst_count1", Count1, 0);
        chk("rst_in_ready", In_Ready, 1);
        chk("rst_data0", Data0, 0);
        chk("rst_data1", Data1, 0);
        sb0.delete();
        sb1.delete();
        occ0 = 0; occ1 = 0; cnt0 = 0; cnt1 = 0;
        @(negedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic drain(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, a);
    endtask

    initial begin
        bit          a;
        bit          v, e, hold;
        logic [31:0] d;

        do_reset();

        // Single word to port 0.
        cycle(1'b1, 1'b0, 32'hAAAA0001, 1'b0, 1'b0, a);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, a);
        drain(2);

        // Port 0 fills and back-pressures; port 1 still accepts.
        do_reset();
        cycle(1'b1, 1'b0, 32'h10, 1'b0, 1'b0, a);
        cycle(1'b1, 1'b0, 32'h11, 1'b0, 1'b0, a);
        cycle(1'b1, 1'b0, 32'h12, 1'b0, 1'b0, a);
        cycle(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, a);
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b1, a);
        drain(4);

        // Alternating destinations at full rate.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, i[0], 32'(i), 1'b1, 1'b1, a);
        drain(3);
        chk("count0_after_alt", Count0, 4);
        chk("count1_after_alt", Count1, 4);

        // Full FIFO: pop proceeds, push refused, then accepted.
        do_reset();
        cycle(1'b1, 1'b0, 32'h40, 1'b0, 1'b0, a);
        cycle(1'b1, 1'b0, 32'h41, 1'b0, 1'b0, a);
        cycle(1'b1, 1'b0, 32'h42, 1'b1, 1'b0, a);
        chk("full_push_refused", a, 0);
        cycle(1'b1, 1'b0, 32'h42, 1'b1, 1'b0, a);
        chk("retry_accepted", a, 1);
        drain(3);

        // Asynchronous reset with both FIFOs full.
        do_reset();
        cycle(1'b1, 1'b0, 32'h50, 1'b0, 1'b0, a);
        cycle(1'b1, 1'b0, 32'h51, 1'b0, 1'b0, a);
        cycle(1'b1, 1'b1, 32'h60, 1'b0, 1'b0, a);
        cycle(1'b1, 1'b1, 32'h61, 1'b0, 1'b0, a);
        do_reset();
        cycle(1'b1, 1'b0, 32'h70, 1'b0, 1'b0, a);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, a);
        drain(2);

        // Counter wrap on port 1.
        do_reset();
        for (int i = 0; i < 257; i++) cycle(1'b1, 1'b1, $urandom, 1'b0, 1'b1, a);
        drain(3);
        chk("count1_wrap", Count1, 1);
        chk("count0_untouched", Count0, 0);

        // Randomised traffic with producer hold on back-pressure.
        do_reset();
        hold = 1'b0;
        v = 1'b0; e = 1'b0; d = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!hold) begin
                v = ($urandom_range(0, 3) != 0);
                e = $urandom_range(0, 1) == 1;
                d = $urandom;
            end
            cycle(v, e, d, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, a);
            hold = v && !a;
        end
        drain(6);
        chk("sb0_empty", sb0.size(), 0);
        chk("sb1_empty", sb1.size(), 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
